// File: rtl/disp_pkg.sv
// Shared types and defaults for the display-source selector.
// Holds the FSM state encoding and the one-hot check.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } disp_state_t;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_NCH        = 3;
    localparam int DEF_BLANK_CYC  = 4;
    localparam int DEF_BLINK_HALF = 8;
    localparam int DEF_BLINK_MASK = 4;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot validity check and index encoder for the channel select.
// Purely combinational; idx is meaningful only when valid is high.
module onehot_enc
    import disp_pkg::*;
#(
    parameter int N  = DEF_NCH,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic          valid,
    output logic [IW-1:0] idx
);

    assign valid = is_onehot(32'(vec));

    // OR together the indices of all set bits
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = idx | IW'(i);
        end
    end

endmodule

// File: rtl/disp_src_sel.sv
// Registered display-source selector with switch blanking,
// per-channel blinking and hold-last-valid on a bad select.
module disp_src_sel
    import disp_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NCH        = DEF_NCH,
    parameter int BLANK_CYC  = DEF_BLANK_CYC,
    parameter int BLINK_HALF = DEF_BLINK_HALF,
    parameter logic [NCH-1:0] BLINK_MASK = NCH'(DEF_BLINK_MASK)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           sel,
    input  logic [NCH*WIDTH-1:0]     ch_data,
    input  logic                     freeze,
    output logic [WIDTH-1:0]         out,
    output logic                     blank,
    output logic [$clog2(NCH)-1:0]   cur_ch,
    output logic                     sel_err
);

    localparam int IW = $clog2(NCH);
    localparam int CW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    disp_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [IW-1:0] cur_d;
    logic [WIDTH-1:0] out_d;
    logic          blank_d;
    logic          sel_ok;
    logic [IW-1:0] sel_idx;
    logic          do_switch;
    logic          enter_show;

    onehot_enc #(.N(NCH), .IW(IW)) u_enc (
        .vec   (sel),
        .valid (sel_ok),
        .idx   (sel_idx)
    );

    // Next-state, counters and registered-output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        phase_d    = phase_q;
        cur_d      = cur_ch;
        enter_show = 1'b0;
        do_switch  = sel_ok && ((state_q == IDLE) || (sel_idx != cur_ch));

        if (do_switch) begin
            cur_d = sel_idx;
            if (BLANK_CYC == 0) begin
                state_d    = SHOW;
                enter_show = 1'b1;
            end else begin
                state_d = BLANK;
                cnt_d   = CW'(BLANK_CYC);
            end
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (cnt_q == CW'(1)) begin
                        state_d    = SHOW;
                        cnt_d      = '0;
                        enter_show = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                SHOW: begin
                    if (bcnt_q == BW'(BLINK_HALF - 1)) begin
                        bcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end

        // Every entry to SHOW starts in the lit half of the blink
        if (enter_show) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end

        out_d   = ch_data[int'(cur_d)*WIDTH +: WIDTH];
        blank_d = (state_d != SHOW) || (BLINK_MASK[cur_d] && phase_d);
    end

    // State and output registers; freeze holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            cur_ch  <= '0;
            out     <= '0;
            blank   <= 1'b1;
            sel_err <= 1'b0;
        end else if (!freeze) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            cur_ch  <= cur_d;
            out     <= out_d;
            blank   <= blank_d;
            sel_err <= ~sel_ok;
        end
    end

endmodule

// File: tb/tb_disp_src_sel.sv
// Self-checking bench for disp_src_sel with default parameters.
// Table rows plus hand sequences for blink and reset.
module tb_disp_src_sel;
    import disp_pkg::*;

    localparam logic [15:0] VA = 16'h1234;
    localparam logic [15:0] VB = 16'h5678;
    localparam logic [15:0] V1 = 16'h0A0A;
    localparam logic [15:0] V2 = 16'h0050;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] d0, d1, d2;
        logic        frz;
        logic [15:0] e_out;
        logic        e_blank;
        logic [1:0]  e_cur;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  sel = 3'b001;
    logic [47:0] ch_data = '0;
    logic        freeze = 1'b0;
    logic [15:0] out;
    logic        blank;
    logic [1:0]  cur_ch;
    logic        sel_err;

    int compared = 0;
    int failed = 0;
    vec_t sb[$];
    vec_t tbl[$];

    disp_src_sel dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .ch_data (ch_data),
        .freeze  (freeze),
        .out     (out),
        .blank   (blank),
        .cur_ch  (cur_ch),
        .sel_err (sel_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] s, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] c,
                                input logic f, input logic [15:0] eo,
                                input logic eb, input logic [1:0] ec,
                                input logic ee);
        vec_t v;
        v.sel = s; v.d0 = a; v.d1 = b; v.d2 = c; v.frz = f;
        v.e_out = eo; v.e_blank = eb; v.e_cur = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        sel = v.sel;
        ch_data = {v.d2, v.d1, v.d0};
        freeze = v.frz;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compared++;
        if (out !== e.e_out || blank !== e.e_blank ||
            cur_ch !== e.e_cur || sel_err !== e.e_err) begin
            failed++;
            $display("FAIL %s: got out=%h blank=%b cur=%0d err=%b want out=%h blank=%b cur=%0d err=%b",
                     nm, out, blank, cur_ch, sel_err,
                     e.e_out, e.e_blank, e.e_cur, e.e_err);
        end
    endtask

    task automatic chk_reset(input string nm);
        compared++;
        if (out !== 16'h0 || blank !== 1'b1 || cur_ch !== 2'd0 ||
            sel_err !== 1'b0 || dut.state_q !== IDLE) begin
            failed++;
            $display("FAIL %s: got out=%h blank=%b cur=%0d err=%b st=%0d want 0/1/0/0/IDLE",
                     nm, out, blank, cur_ch, sel_err, dut.state_q);
        end
    endtask

    initial begin
        // startup to ch0
        for (int i = 0; i < 4; i++) tbl.push_back(mk(3'b001, VA, V1, V2, 0, VA, 1, 0, 0));
        tbl.push_back(mk(3'b001, VA, V1, V2, 0, VA, 0, 0, 0));
        // tracking on ch0
        tbl.push_back(mk(3'b001, VB, V1, V2, 0, VB, 0, 0, 0));
        // switch to ch1
        for (int i = 0; i < 4; i++) tbl.push_back(mk(3'b010, VB, V1, V2, 0, V1, 1, 1, 0));
        tbl.push_back(mk(3'b010, VB, V1, V2, 0, V1, 0, 1, 0));
        // illegal selects then restore
        tbl.push_back(mk(3'b011, VB, V1, V2, 0, V1, 0, 1, 1));
        tbl.push_back(mk(3'b000, VB, V1, V2, 0, V1, 0, 1, 1));
        tbl.push_back(mk(3'b010, VB, V1, V2, 0, V1, 0, 1, 0));
        tbl.push_back(mk(3'b010, VB, V1, V2, 0, V1, 0, 1, 0));
        // switch to ch0, then ch2 on second blank cycle
        for (int i = 0; i < 2; i++) tbl.push_back(mk(3'b001, VB, V1, V2, 0, VB, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(3'b100, VB, V1, V2, 0, V2, 1, 2, 0));
        tbl.push_back(mk(3'b100, VB, V1, V2, 0, V2, 0, 2, 0));
        // freeze holds everything, even with a bad select
        tbl.push_back(mk(3'b001, VB, V1, 16'hFFFF, 1, V2, 0, 2, 0));
        tbl.push_back(mk(3'b011, VB, V1, 16'hFFFF, 1, V2, 0, 2, 0));
        // release: switch starts at once
        tbl.push_back(mk(3'b001, VB, V1, V2, 0, VB, 1, 0, 0));
        tbl.push_back(mk(3'b001, VB, V1, V2, 0, VB, 1, 0, 0));

        rst_n = 1'b0;
        sel = 3'b001;
        ch_data = {V2, V1, VA};
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset_hold");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // async reset in the middle of a blank interval
        rst_n = 1'b0;
        #1;
        chk_reset("reset_mid_blank");
        @(posedge clk);
        #1;
        chk_reset("reset_held");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            apply(mk(3'b001, VB, V1, V2, 0, VB, 1, 0, 0), $sformatf("restart%0d", i));
        apply(mk(3'b001, VB, V1, V2, 0, VB, 0, 0, 0), "restart_show");

        // blink channel: 4 blank, then 8 lit / 8 dark / 8 lit
        for (int k = 0; k < 28; k++) begin
            logic eb;
            eb = (k < 4) ? 1'b1 : ((((k - 4) / 8) % 2) == 1);
            apply(mk(3'b100, VB, V1, V2, 0, V2, eb, 2, 0), $sformatf("blink%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
